// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird LED column cells.
package flappy_pkg;

   // Occupancy state of one column cell; shared by the centre cell and the normal cell.
   typedef enum logic {
      LIGHT_ON,
      LIGHT_OFF
   } light_state_t;

   // Number of cells in the vertical LED column.
   localparam int COLUMN_HEIGHT = 8;

endpackage : flappy_pkg

// File: rtl/key_edge_latch.sv
// Turns the player key into a one-step-per-press request: registers `up`,
// catches its rising edge in a sticky flag, and hands the request to the
// next game tick, which consumes it. Used only when CENTER_LIGHT_UP_EDGE_EN
// is defined.
module key_edge_latch (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic up,
   output logic upEff
);

   logic upReg;
   logic pressFlag;
   logic upRise;

   assign upRise = up & ~upReg;
   // A press seen on the tick itself counts immediately; otherwise the flag carries it.
   assign upEff  = pressFlag | upRise;

   // Track the previous key level and hold a pending press until a tick consumes it.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         upReg     <= 1'b0;
         pressFlag <= 1'b0;
      end else begin
         upReg <= up;
         // Every tick consumes the request, frozen or not; a frozen tick simply discards it.
         if (enable)
            pressFlag <= 1'b0;
         else if (upRise)
            pressFlag <= 1'b1;
      end
   end

endmodule : key_edge_latch

// File: rtl/center_light.sv
// Centre-row cell of the Flappy Bird LED column. Holds "bird is here" and
// advances on game ticks: the bird always leaves on a tick, and enters from
// below when rising or from above when falling.
// Optional feature macro: CENTER_LIGHT_UP_EDGE_EN (edge-triggered key, one
// upward step per press). Default build uses the key level directly.
module center_light
   import flappy_pkg::*;
#(
   parameter logic RESET_ON = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic gameOver,
   input  logic enable,
   input  logic up,
   input  logic above,
   input  logic below,
   output logic lightOn
);

   light_state_t state;
   logic         upEff;

`ifdef CENTER_LIGHT_UP_EDGE_EN
   key_edge_latch keyLatch (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .up     (up),
      .upEff  (upEff)
   );
`else
   assign upEff = up;
`endif

   // Advance occupancy on enabled, non-frozen ticks; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RESET_ON ? LIGHT_ON : LIGHT_OFF;
      end else if (enable && !gameOver) begin
         case (state)
            LIGHT_ON:  state <= LIGHT_OFF;
            LIGHT_OFF: state <= ((below & upEff) | (above & ~upEff)) ? LIGHT_ON : LIGHT_OFF;
            default:   state <= LIGHT_OFF;
         endcase
      end
   end

   // Pure decode of the state flop; no input reaches the LED combinationally.
   assign lightOn = (state == LIGHT_ON);

endmodule : center_light

// File: tb/tb_center_light.sv
// Directed bench for center_light: a RESET_ON=1 cell under test plus a
// RESET_ON=0 cell sharing the same inputs, checked for its reset value.
module tb_center_light;

   logic clk = 1'b0;
   logic reset, gameOver, enable, up, above, below;
   logic lightOn, lightOnDark;

   int testsRun    = 0;
   int testsFailed = 0;

   center_light #(.RESET_ON(1'b1)) dut (
      .clk      (clk),
      .reset    (reset),
      .gameOver (gameOver),
      .enable   (enable),
      .up       (up),
      .above    (above),
      .below    (below),
      .lightOn  (lightOn)
   );

   center_light #(.RESET_ON(1'b0)) dutDark (
      .clk      (clk),
      .reset    (reset),
      .gameOver (gameOver),
      .enable   (enable),
      .up       (up),
      .above    (above),
      .below    (below),
      .lightOn  (lightOnDark)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic observed, input logic expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("FAIL %s: observed %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic setIn(input logic u, input logic a, input logic b);
      up    = u;
      above = a;
      below = b;
   endtask

   logic [3:0] edgeExp;

   initial begin
      reset = 1'b1; gameOver = 1'b0; enable = 1'b0;
      setIn(1'b0, 1'b0, 1'b0);
      #2;

      // Reset: lit cell comes up on, dark cell comes up off.
      step();
      reset = 1'b0;
      check("reset_on",  lightOn,     1'b1);
      check("reset_off", lightOnDark, 1'b0);

      // Freeze by gameOver: 5 enabled ticks with varied neighbours/key.
      enable = 1'b1; gameOver = 1'b1;
      for (int i = 0; i < 5; i++) begin
         setIn(i[0], i[1], i[2]);
         step();
         check($sformatf("freeze_gameover_%0d", i), lightOn, 1'b1);
      end

      // Freeze by enable=0: hold for 5 edges.
      gameOver = 1'b0; enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         setIn(i[2], i[0], i[1]);
         step();
         check($sformatf("freeze_disable_%0d", i), lightOn, 1'b1);
      end

      // One live tick to go dark, then reset while gameOver is high relights.
      enable = 1'b1;
      setIn(1'b0, 1'b0, 1'b0);
      step();
      check("leave_before_reset", lightOn, 1'b0);
      reset = 1'b1; gameOver = 1'b1;
      step();
      check("reset_over_gameover",      lightOn,     1'b1);
      check("reset_over_gameover_dark", lightOnDark, 1'b0);
      reset = 1'b0; gameOver = 1'b0;

      // Fall out: dark after one tick and stays dark with no neighbours.
      setIn(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("fall_out_%0d", i), lightOn, 1'b0);
      end

`ifndef CENTER_LIGHT_UP_EDGE_EN
      // Rise in from below with the key held: on, leave upward, on again.
      setIn(1'b1, 1'b0, 1'b1);
      step(); check("rise_in_1", lightOn, 1'b1);
      step(); check("rise_in_2", lightOn, 1'b0);
      step(); check("rise_in_3", lightOn, 1'b1);

      // Fall in from above, then leave with the key pressed.
      setIn(1'b0, 1'b0, 1'b0);
      step(); check("fall_in_prep", lightOn, 1'b0);
      setIn(1'b0, 1'b1, 1'b0);
      step(); check("fall_in", lightOn, 1'b1);
      setIn(1'b1, 1'b0, 1'b0);
      step(); check("fall_in_leave", lightOn, 1'b0);

      // Both neighbours lit: the key alone decides entry.
      setIn(1'b1, 1'b1, 1'b1);
      step(); check("both_up",       lightOn, 1'b1);
      step(); check("both_up_leave", lightOn, 1'b0);
      setIn(1'b0, 1'b1, 1'b1);
      step(); check("both_fall",     lightOn, 1'b1);
`endif

      // Return to dark; a key press with no neighbours must not light the cell.
      setIn(1'b0, 1'b0, 1'b0);
      step(); check("edge_prep", lightOn, 1'b0);
      setIn(1'b1, 1'b0, 1'b0);
      step(); check("isolated_up", lightOn, 1'b0);
      setIn(1'b0, 1'b0, 1'b0);
      step(); check("isolated_release", lightOn, 1'b0);

      // Key held high for 4 ticks with the bird below.
`ifdef CENTER_LIGHT_UP_EDGE_EN
      edgeExp = 4'b0001;
`else
      edgeExp = 4'b0101;
`endif
      setIn(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("held_up_%0d", i), lightOn, edgeExp[i]);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule : tb_center_light

// File: doc/center_light.md
Name: center_light

Overview:
- One cell of the Flappy Bird vertical LED column: the centre row, where the bird starts.
- Holds a one-bit "bird is here" state, advanced on game ticks (`enable`).
- The bird moves up on a key press and falls otherwise.
- Neighbouring cells' `lightOn` outputs feed `above`/`below`; the column is a chain of these cells plus ordinary cells.

Parameters:
- RESET_ON, 1'b1, state loaded on reset. 1 = lit (the bird starts here, centre-row default); 0 = dark (makes the block usable as an ordinary cell).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- gameOver  input  1  freezes state while high
- enable  input  1  game-tick strobe; state advances only on cycles where it is high
- up  input  1  player key pressed (bird rises); level-sensitive unless CENTER_LIGHT_UP_EDGE_EN
- above  input  1  lightOn of the cell directly above
- below  input  1  lightOn of the cell directly below
- lightOn  output  1  LED drive; high when the bird occupies this cell

Behaviour:
- One clock; reset is synchronous and active-high.
- Two states: LIGHT_ON, LIGHT_OFF.
- Moore output: lightOn = (state == LIGHT_ON). No combinational path from inputs to lightOn.
- Reset: on a rising edge with reset=1, state = RESET_ON, regardless of enable or gameOver. With default parameters, lightOn = 1 in the cycle after reset.
- Priority at each rising edge: reset > (enable=0: hold) > (gameOver=1: hold) > next-state logic.
- Next state from LIGHT_ON: LIGHT_OFF unconditionally. The bird always leaves the cell on a tick, rising or falling.
- Next state from LIGHT_OFF:
  - LIGHT_ON if (below & up_eff), i.e. the bird rises in from below.
  - LIGHT_ON if (above & ~up_eff), i.e. the bird falls in from above.
  - Otherwise stays LIGHT_OFF.
- up_eff = up, unless the optional feature is enabled.
- above=1 and below=1 together: the result is decided by up_eff alone, per the rules above. No error flag.
- above=0, below=0 while off: stays off regardless of up.
- Latency: one clock from the enabling edge to the lightOn change.
- Reset asserted mid-game: the next edge restores RESET_ON, and gameOver is ignored.
- Inputs are sampled only on edges where enable=1. Values between ticks have no effect, except under the optional feature.
- X on gameOver after reset is illegal: the environment drives gameOver=0 from the first cycle after reset.

Optional Feature:
- Macro: CENTER_LIGHT_UP_EDGE_EN.
- Defined:
  - `up` is registered each clock.
  - A rising edge of `up` sets a sticky press flag.
  - On the next enabled, non-frozen tick, up_eff = press flag OR (current rising edge), and the flag is then cleared.
  - Holding the key gives exactly one upward step; later ticks see up_eff=0, so the bird falls.
  - reset clears the flag and the `up` register.
  - While gameOver=1, the flag is cleared on ticks.
- Not defined: up_eff = up (level), with no extra registers.

Decomposition:
- Shared package `flappy_pkg`:
  - typedef enum logic {LIGHT_ON, LIGHT_OFF} light_state_t, also used by the normal light cell.
  - Localparam for the column height.
- Optional sub-module `key_edge_latch` (registered edge detect + sticky flag), instantiated only under CENTER_LIGHT_UP_EDGE_EN. No other sub-modules.

Test Plan:
- Reset: reset=1 for one edge, then 0 → lightOn=1 (RESET_ON=1). With RESET_ON=0 → lightOn=0.
- Fall out:
  - Stimulus: after reset, enable=1, gameOver=0, up=0, above=0, below=0.
  - Response: lightOn=0 after 1 edge and stays 0 for 3 more edges.
- Rise in:
  - Stimulus: from off, up=1, below=1, above=0.
  - Response: lightOn=1 after 1 edge, 0 after the 2nd edge (leaves upward), 1 again after the 3rd.
- Fall in:
  - Stimulus: from off, up=0, above=1, below=0.
  - Response: lightOn=1 after 1 edge. Then up=1, above=0, below=0 → lightOn=0.
- Freeze:
  - gameOver=1 while lightOn=1 → stays 1 for 5 enabled edges under any up/above/below.
  - enable=0 with gameOver=0 → holds for 5 edges.
  - Then reset=1 with gameOver still 1 → lightOn=1 after 1 edge.
- Edge feature (macro defined): from off with below=1, up held high for 4 ticks → lightOn goes 1 on the first tick, then 0, and does not re-light on later ticks while up remains high.
